// File: rtl/cpu_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_fsm
//   Moore control FSM for the simple RISC datapath. Sequences fetch, decode and
//   execute for MOV (imm/reg), MVN, ADD, CMP, AND, LDR, STR and HALT, and shares
//   the single RAM port between instruction fetch and data access. Only
//   ir[15:11] is decoded here; the datapath decodes register/immediate fields.
//
//   Optional feature macro: CTRL_PERF_EN (retired-instruction counter).
//
// Parameters
//   MEM_LAT    RAM read latency in cycles (1..7); mem_rd is held that long
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   start_pc   in   [7:0]  PC value loaded in the RESET state
//   ir         in   [15:0] instruction register contents
//   load_pc    out  PC load enable
//   pc_sel     out  1: PC <= start_pc, 0: PC <= PC + 1
//   load_ir    out  IR <= RAM read data
//   addr_sel   out  RAM address mux: 1 PC, 0 data-address register
//   load_addr  out  data-address register <= C[7:0]
//   mem_rd     out  RAM read strobe
//   mem_wr     out  RAM write strobe (write data = C)
//   reg_sel    out  [1:0] regfile index: 0 Rm, 1 Rd, 2 Rn
//   w_en       out  regfile write enable
//   load_a     out  A register enable
//   load_b     out  B register enable
//   load_c     out  C register enable
//   asel       out  1: ALU A input forced to 0
//   bsel       out  1: ALU B input = sximm5
//   vsel       out  [1:0] writeback mux: 0 C, 1 sximm8, 2 mdata
//   halted     out  high while in HALT
//   perf_cnt   out  [15:0] retired-instruction count (zero without CTRL_PERF_EN)
//
// Handshake: there is no valid/ready pairing here. Every strobe is a
//   single-level enable that the datapath acts on at the next rising edge;
//   mem_rd is held for MEM_LAT consecutive cycles and the read data is taken
//   (load_ir or vsel=2 with w_en) in the cycle right after the last one.
// -----------------------------------------------------------------------------
module cpu_ctrl_fsm #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  start_pc,
  input  logic [15:0] ir,
  output logic        load_pc,
  output logic        pc_sel,
  output logic        load_ir,
  output logic        addr_sel,
  output logic        load_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [1:0]  reg_sel,
  output logic        w_en,
  output logic        load_a,
  output logic        load_b,
  output logic        load_c,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic        halted,
  output logic [15:0] perf_cnt
);

  typedef enum logic [4:0] {
    S_RESET_HOLD,
    S_RESET,
    S_FETCH,
    S_LOAD_IR,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WB,
    S_WB_IMM,
    S_ADDR,
    S_LOAD_ADDR,
    S_MEM_RD,
    S_WB_MEM,
    S_STR_B,
    S_STR_C,
    S_MEM_WR,
    S_HALT
  } state_t;

  localparam logic [4:0] OP_MOV_IMM = 5'b11010;
  localparam logic [4:0] OP_MOV_REG = 5'b11000;
  localparam logic [4:0] OP_MVN     = 5'b10111;
  localparam logic [4:0] OP_ADD     = 5'b10100;
  localparam logic [4:0] OP_CMP     = 5'b10101;
  localparam logic [4:0] OP_AND     = 5'b10110;
  localparam logic [4:0] OP_LDR     = 5'b01100;
  localparam logic [4:0] OP_STR     = 5'b10000;
  localparam logic [4:0] OP_HALT    = 5'b11100;

  // Reload value for the RAM wait down-counter.
  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_t     state;
  state_t     state_next;
  logic [2:0] wait_cnt;

  logic [4:0] opcode;
  logic       is_move;   // MOV reg / MVN: ALU A input is zeroed
  logic       is_cmp;
  logic       is_mem;
  logic       is_ldr;

  // The datapath consumes the low instruction fields.
  logic unused_ir;
  assign unused_ir = ^ir[10:0];

  assign opcode  = ir[15:11];
  assign is_move = (opcode == OP_MOV_REG) || (opcode == OP_MVN);
  assign is_cmp  = (opcode == OP_CMP);
  assign is_ldr  = (opcode == OP_LDR);
  assign is_mem  = (opcode == OP_LDR) || (opcode == OP_STR);

  // State register and RAM wait counter. The counter is reloaded whenever a
  // RAM-read state is entered and counts down to zero while it is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RESET_HOLD;
      wait_cnt <= 3'd0;
    end else begin
      state <= state_next;
      if ((state_next != state) &&
          ((state_next == S_FETCH) || (state_next == S_MEM_RD))) begin
        wait_cnt <= LAT_M1;
      end else if (wait_cnt != 3'd0) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
    end
  end

  // Next state and Moore outputs. The final rst override keeps every strobe
  // low for the whole of any cycle in which rst is high, including the cycle
  // in which rst is first raised while the old state is still registered.
  always_comb begin
    state_next = state;
    load_pc    = 1'b0;
    pc_sel     = 1'b0;
    load_ir    = 1'b0;
    addr_sel   = 1'b0;
    load_addr  = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_sel    = 2'd0;
    w_en       = 1'b0;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_c     = 1'b0;
    asel       = 1'b0;
    bsel       = 1'b0;
    vsel       = 2'd0;
    halted     = 1'b0;

    case (state)
      S_RESET_HOLD: state_next = S_RESET;
      S_RESET: begin
        load_pc    = 1'b1;
        pc_sel     = 1'b1;
        state_next = S_FETCH;
      end
      S_FETCH: begin
        addr_sel = 1'b1;
        mem_rd   = 1'b1;
        if (wait_cnt == 3'd0) state_next = S_LOAD_IR;
      end
      S_LOAD_IR: begin
        load_ir    = 1'b1;
        load_pc    = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_MOV_IMM:                 state_next = S_WB_IMM;
          OP_MOV_REG, OP_MVN:         state_next = S_GET_B;
          OP_ADD, OP_CMP, OP_AND:     state_next = S_GET_A;
          OP_LDR, OP_STR:             state_next = S_GET_A;
          OP_HALT:                    state_next = S_HALT;
          default:                    state_next = S_FETCH;  // NOP
        endcase
      end
      S_GET_A: begin
        reg_sel    = 2'd2;
        load_a     = 1'b1;
        state_next = is_mem ? S_ADDR : S_GET_B;
      end
      S_GET_B: begin
        reg_sel    = 2'd0;
        load_b     = 1'b1;
        state_next = S_EXEC;
      end
      S_EXEC: begin
        load_c     = 1'b1;
        asel       = is_move;
        state_next = is_cmp ? S_FETCH : S_WB;
      end
      S_WB: begin
        reg_sel    = 2'd1;
        vsel       = 2'd0;
        w_en       = 1'b1;
        state_next = S_FETCH;
      end
      S_WB_IMM: begin
        reg_sel    = 2'd2;
        vsel       = 2'd1;
        w_en       = 1'b1;
        state_next = S_FETCH;
      end
      S_ADDR: begin
        bsel       = 1'b1;
        load_c     = 1'b1;
        state_next = S_LOAD_ADDR;
      end
      S_LOAD_ADDR: begin
        load_addr  = 1'b1;
        state_next = is_ldr ? S_MEM_RD : S_STR_B;
      end
      S_MEM_RD: begin
        mem_rd = 1'b1;
        if (wait_cnt == 3'd0) state_next = S_WB_MEM;
      end
      S_WB_MEM: begin
        reg_sel    = 2'd1;
        vsel       = 2'd2;
        w_en       = 1'b1;
        state_next = S_FETCH;
      end
      S_STR_B: begin
        reg_sel    = 2'd1;
        load_b     = 1'b1;
        state_next = S_STR_C;
      end
      S_STR_C: begin
        asel       = 1'b1;
        load_c     = 1'b1;
        state_next = S_MEM_WR;
      end
      S_MEM_WR: begin
        mem_wr     = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT: begin
        halted     = 1'b1;
        state_next = S_HALT;
      end
      default: state_next = S_RESET_HOLD;
    endcase

    if (rst) begin
      load_pc   = 1'b0;
      pc_sel    = 1'b0;
      load_ir   = 1'b0;
      addr_sel  = 1'b0;
      load_addr = 1'b0;
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      reg_sel   = 2'd0;
      w_en      = 1'b0;
      load_a    = 1'b0;
      load_b    = 1'b0;
      load_c    = 1'b0;
      asel      = 1'b0;
      bsel      = 1'b0;
      vsel      = 2'd0;
      halted    = 1'b0;
    end
  end

`ifdef CTRL_PERF_EN
  // An instruction retires when FETCH is entered from a completing state;
  // the entry from RESET starts the first instruction and is not counted.
  logic [15:0] perf_q;
  logic        retire;

  assign retire = (state_next == S_FETCH) && (state != S_FETCH) &&
                  (state != S_RESET);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= 16'h0000;
    end else if (retire && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'h0001;
    end
  end

  assign perf_cnt = perf_q;
`else
  assign perf_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_cpu_ctrl_fsm
//   Bench for cpu_ctrl_fsm. Two instances share all inputs: one with
//   MEM_LAT=1 and one with MEM_LAT=2. Each phase resets both, holds one
//   instruction word on ir (the FSM re-executes it every pass) and pushes the
//   cycle-by-cycle expected output vector and perf_cnt for each instance into
//   its queue. A monitor pops one entry per instance per clock and compares.
//   Inputs change on the falling edge; outputs are sampled 1 time unit after
//   the rising edge.
// -----------------------------------------------------------------------------
module tb_cpu_ctrl_fsm;

  localparam int W = 34;  // {perf_cnt[15:0], outputs[17:0]}

  // Output vector bit map: [17] load_pc [16] pc_sel [15] load_ir
  // [14] addr_sel [13] load_addr [12] mem_rd [11] mem_wr [10:9] reg_sel
  // [8] w_en [7] load_a [6] load_b [5] load_c [4] asel [3] bsel [2:1] vsel
  // [0] halted
  localparam logic [17:0] B_LOAD_PC   = 18'h20000;
  localparam logic [17:0] B_PC_SEL    = 18'h10000;
  localparam logic [17:0] B_LOAD_IR   = 18'h08000;
  localparam logic [17:0] B_ADDR_SEL  = 18'h04000;
  localparam logic [17:0] B_LOAD_ADDR = 18'h02000;
  localparam logic [17:0] B_MEM_RD    = 18'h01000;
  localparam logic [17:0] B_MEM_WR    = 18'h00800;
  localparam logic [17:0] RS_RN       = 18'h00400;  // reg_sel = 2
  localparam logic [17:0] RS_RD       = 18'h00200;  // reg_sel = 1
  localparam logic [17:0] B_W_EN      = 18'h00100;
  localparam logic [17:0] B_LOAD_A    = 18'h00080;
  localparam logic [17:0] B_LOAD_B    = 18'h00040;
  localparam logic [17:0] B_LOAD_C    = 18'h00020;
  localparam logic [17:0] B_ASEL      = 18'h00010;
  localparam logic [17:0] B_BSEL      = 18'h00008;
  localparam logic [17:0] VS_MEM      = 18'h00004;  // vsel = 2
  localparam logic [17:0] VS_IMM      = 18'h00002;  // vsel = 1
  localparam logic [17:0] B_HALTED    = 18'h00001;
  localparam logic [17:0] V_ZERO      = 18'h00000;

  // ---------------------------------------------------------------- clock/reset
  logic        clk;
  logic        rst;
  logic [7:0]  start_pc;
  logic [15:0] ir;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUTs
  wire [17:0] o1;
  wire [17:0] o2;
  wire [15:0] perf1;
  wire [15:0] perf2;

  cpu_ctrl_fsm #(.MEM_LAT(1)) dut_l1 (
    .clk(clk), .rst(rst), .start_pc(start_pc), .ir(ir),
    .load_pc(o1[17]), .pc_sel(o1[16]), .load_ir(o1[15]), .addr_sel(o1[14]),
    .load_addr(o1[13]), .mem_rd(o1[12]), .mem_wr(o1[11]), .reg_sel(o1[10:9]),
    .w_en(o1[8]), .load_a(o1[7]), .load_b(o1[6]), .load_c(o1[5]),
    .asel(o1[4]), .bsel(o1[3]), .vsel(o1[2:1]), .halted(o1[0]),
    .perf_cnt(perf1)
  );

  cpu_ctrl_fsm #(.MEM_LAT(2)) dut_l2 (
    .clk(clk), .rst(rst), .start_pc(start_pc), .ir(ir),
    .load_pc(o2[17]), .pc_sel(o2[16]), .load_ir(o2[15]), .addr_sel(o2[14]),
    .load_addr(o2[13]), .mem_rd(o2[12]), .mem_wr(o2[11]), .reg_sel(o2[10:9]),
    .w_en(o2[8]), .load_a(o2[7]), .load_b(o2[6]), .load_c(o2[5]),
    .asel(o2[4]), .bsel(o2[3]), .vsel(o2[2:1]), .halted(o2[0]),
    .perf_cnt(perf2)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];
  logic [17:0]  seq_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s @%0t: got perf=%h out=%h, expected perf=%h out=%h",
               tag, $time, got[33:18], got[17:0], exp[33:18], exp[17:0]);
    end
  endtask

  task automatic push_exp(input int dut, input int retired, input logic [17:0] v);
    logic [15:0] p;
`ifdef CTRL_PERF_EN
    p = 16'(retired);
`else
    p = 16'h0000;
`endif
    if (dut == 1) exp_q1.push_back({p, v});
    else          exp_q2.push_back({p, v});
  endtask

  // One instruction from FETCH entry up to (not including) the next FETCH.
  task automatic gen_seq(input int lat, input logic [4:0] op);
    seq_q.delete();
    for (int i = 0; i < lat; i++) seq_q.push_back(B_ADDR_SEL | B_MEM_RD);
    seq_q.push_back(B_LOAD_IR | B_LOAD_PC);
    seq_q.push_back(V_ZERO);  // DECODE
    case (op)
      5'b11010: seq_q.push_back(RS_RN | VS_IMM | B_W_EN);
      5'b11000, 5'b10111: begin
        seq_q.push_back(B_LOAD_B);
        seq_q.push_back(B_LOAD_C | B_ASEL);
        seq_q.push_back(RS_RD | B_W_EN);
      end
      5'b10100, 5'b10110: begin
        seq_q.push_back(RS_RN | B_LOAD_A);
        seq_q.push_back(B_LOAD_B);
        seq_q.push_back(B_LOAD_C);
        seq_q.push_back(RS_RD | B_W_EN);
      end
      5'b10101: begin
        seq_q.push_back(RS_RN | B_LOAD_A);
        seq_q.push_back(B_LOAD_B);
        seq_q.push_back(B_LOAD_C);
      end
      5'b01100: begin
        seq_q.push_back(RS_RN | B_LOAD_A);
        seq_q.push_back(B_BSEL | B_LOAD_C);
        seq_q.push_back(B_LOAD_ADDR);
        for (int i = 0; i < lat; i++) seq_q.push_back(B_MEM_RD);
        seq_q.push_back(RS_RD | VS_MEM | B_W_EN);
      end
      5'b10000: begin
        seq_q.push_back(RS_RN | B_LOAD_A);
        seq_q.push_back(B_BSEL | B_LOAD_C);
        seq_q.push_back(B_LOAD_ADDR);
        seq_q.push_back(RS_RD | B_LOAD_B);
        seq_q.push_back(B_ASEL | B_LOAD_C);
        seq_q.push_back(B_MEM_WR);
      end
      5'b11100: seq_q.push_back(B_HALTED);
      default: ;  // NOP goes straight back to FETCH
    endcase
  endtask

  // Expected stream for n cycles of a repeating instruction.
  task automatic push_run(input int dut, input int lat, input logic [4:0] op,
                          input int n);
    int cnt = 0;
    int k   = 0;
    while (cnt < n) begin
      gen_seq(lat, op);
      foreach (seq_q[i]) begin
        if (cnt < n) begin
          push_exp(dut, k, seq_q[i]);
          cnt++;
        end
      end
      if (op == 5'b11100) begin
        while (cnt < n) begin
          push_exp(dut, k, B_HALTED);
          cnt++;
        end
      end
      k++;
    end
  endtask

  // ---------------------------------------------------------------- driver
  // Called on a falling edge; returns on the falling edge at which the last
  // expected entry has just been compared. t counts every compared cycle,
  // the two reset cycles and the RESET cycle included.
  task automatic run_phase(input logic [15:0] ir_v, input logic [7:0] spc,
                           input logic [7:0] spc_late, input int t);
    ir       = ir_v;
    start_pc = spc;
    rst      = 1'b1;
    for (int d = 1; d <= 2; d++) begin
      push_exp(d, 0, V_ZERO);
      push_exp(d, 0, V_ZERO);
      push_exp(d, 0, B_LOAD_PC | B_PC_SEL);
      push_run(d, d, ir_v[15:11], t - 3);  // instance d has MEM_LAT = d
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < t - 2; i++) begin
      if (i == t / 2) start_pc = spc_late;
      @(negedge clk);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  logic [W-1:0] mon_e1;
  logic [W-1:0] mon_e2;

  always @(posedge clk) begin
    #1;
    if (exp_q1.size() != 0) begin
      mon_e1 = exp_q1.pop_front();
      check("lat1", {perf1, o1}, mon_e1);
    end
    if (exp_q2.size() != 0) begin
      mon_e2 = exp_q2.pop_front();
      check("lat2", {perf2, o2}, mon_e2);
    end
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [4:0]  rop;
    logic [10:0] rlow;
    rst      = 1'b1;
    ir       = 16'h0000;
    start_pc = 8'h00;
    @(negedge clk);

    run_phase(16'hD045, 8'h1B, 8'h1B, 40);  // MOV R0,#69
    run_phase(16'hA069, 8'h10, 8'h11, 40);  // ADD R3,R0,R1,LSL#1
    run_phase(16'h6021, 8'h20, 8'h21, 40);  // LDR R1,[R0,#1]
    run_phase(16'h8021, 8'h30, 8'h31, 40);  // STR R1,[R0,#1]
    // STR again, cut short: the next phase raises rst while the MEM_LAT=1
    // instance sits in STR_C (and the MEM_LAT=2 one in STR_B).
    run_phase(16'h8021, 8'h40, 8'h40, 11);
    run_phase(16'hA8E1, 8'h5A, 8'h5A, 30);  // CMP
    run_phase(16'hB0A2, 8'h60, 8'h60, 30);  // AND
    run_phase(16'hB861, 8'h70, 8'h70, 30);  // MVN
    run_phase(16'hC022, 8'h80, 8'h80, 30);  // MOV reg
    run_phase(16'hF800, 8'h90, 8'h90, 20);  // unassigned opcode -> NOP
    for (int r = 0; r < 6; r++) begin
      rop  = 5'($urandom_range(0, 31));
      rlow = 11'($urandom_range(0, 2047));
      run_phase({rop, rlow}, 8'($urandom_range(0, 255)), 8'h00, 30);
    end
    run_phase(16'hE000, 8'hA0, 8'h3C, 120);  // HALT, start_pc moved mid-halt

    @(negedge clk);
    check("q1_drained", W'(exp_q1.size()), W'(0));
    check("q2_drained", W'(exp_q2.size()), W'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
